brent_kung_adder_pipe: RTL

//  Parametrised, pipelined Brent-Kung prefix adder/subtractor with valid/ready handshake.

---
 rtl/brent_kung_adder_pipe.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/brent_kung_adder_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : brent_kung_adder_pipe
// Description : Pipelined, WIDTH-generic Brent-Kung prefix adder/subtractor
//               with valid/ready handshake and one beat per cycle throughput.
//               S1 registers the conditioned operands, the up-sweep of the
//               prefix tree runs after S1, an optional S2 (PIPE_MID=1) cuts
//               between up-sweep and down-sweep, and S3 registers the result.
// Parameters  : WIDTH    operand width, power of two and >= 2
//               PIPE_MID 1 = register between up-sweep and down-sweep
// Ports       : clk, rst (async, active high)
//               in_valid/in_ready, a, b, cin, sub   - operand beat
//               out_valid/out_ready, sum, cout[, ovf] - result beat
// Macro       : BKA_OVF_EN - adds the signed-overflow output ovf
// Revision    : 1.0 - initial release
// ============================================================================
module brent_kung_adder_pipe #(
    parameter int WIDTH    = 16,
    parameter int PIPE_MID = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef BKA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int c_LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_width_check
        $error("brent_kung_adder_pipe: WIDTH must be a power of two >= 2");
    end

    // ---------------- handshake enables ----------------
    logic w_s1_en;
    logic w_mid_en;
    logic w_s3_en;
    logic w_mid_vld;

    // ---------------- S1: conditioned operands ----------------
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;    // b already inverted for subtract
    logic             r_s1_c;    // effective carry-in

    assign w_s1_en  = !r_s1_vld || w_mid_en;
    assign in_ready = w_s1_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_c   <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_a <= a;
                r_s1_b <= sub ? ~b : b;
                r_s1_c <= cin ^ sub;
            end
        end
    end

    // ---------------- up-sweep (reduction) ----------------
    // Level k+1 combines span-2^k groups into span-2^(k+1) groups at indices
    // that sit on top of an aligned group; every other bit passes through.
    logic [WIDTH-1:0] w_gu [0:c_LEVELS];
    logic [WIDTH-1:0] w_pu [0:c_LEVELS];

    always_comb begin
        w_gu[0] = r_s1_a & r_s1_b;
        w_pu[0] = r_s1_a ^ r_s1_b;
        for (int k = 0; k < c_LEVELS; k++) begin
            w_gu[k+1] = w_gu[k];
            w_pu[k+1] = w_pu[k];
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (2 << k)) == 0) begin
                    w_gu[k+1][i] = w_gu[k][i] | (w_pu[k][i] & w_gu[k][i - (1 << k)]);
                    w_pu[k+1][i] = w_pu[k][i] & w_pu[k][i - (1 << k)];
                end
            end
        end
    end

    // ---------------- mid boundary (optional S2) ----------------
    logic [WIDTH-1:0] w_mid_g;   // up-sweep group generate
    logic [WIDTH-1:0] w_mid_pp;  // up-sweep group propagate
    logic [WIDTH-1:0] w_mid_p;   // bitwise propagate for the final xor
    logic             w_mid_c;
`ifdef BKA_OVF_EN
    logic             w_mid_amsb;
`endif

    if (PIPE_MID != 0) begin : g_mid
        logic             r_s2_vld;
        logic [WIDTH-1:0] r_s2_g;
        logic [WIDTH-1:0] r_s2_pp;
        logic [WIDTH-1:0] r_s2_p;
        logic             r_s2_c;
`ifdef BKA_OVF_EN
        logic             r_s2_amsb;
`endif
        assign w_mid_en = !r_s2_vld || w_s3_en;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s2_vld  <= 1'b0;
                r_s2_g    <= '0;
                r_s2_pp   <= '0;
                r_s2_p    <= '0;
                r_s2_c    <= 1'b0;
`ifdef BKA_OVF_EN
                r_s2_amsb <= 1'b0;
`endif
            end else if (w_mid_en) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_g    <= w_gu[c_LEVELS];
                    r_s2_pp   <= w_pu[c_LEVELS];
                    r_s2_p    <= w_pu[0];
                    r_s2_c    <= r_s1_c;
`ifdef BKA_OVF_EN
                    r_s2_amsb <= r_s1_a[WIDTH-1];
`endif
                end
            end
        end

        assign w_mid_vld  = r_s2_vld;
        assign w_mid_g    = r_s2_g;
        assign w_mid_pp   = r_s2_pp;
        assign w_mid_p    = r_s2_p;
        assign w_mid_c    = r_s2_c;
`ifdef BKA_OVF_EN
        assign w_mid_amsb = r_s2_amsb;
`endif
    end else begin : g_no_mid
        assign w_mid_en   = w_s3_en;
        assign w_mid_vld  = r_s1_vld;
        assign w_mid_g    = w_gu[c_LEVELS];
        assign w_mid_pp   = w_pu[c_LEVELS];
        assign w_mid_p    = w_pu[0];
        assign w_mid_c    = r_s1_c;
`ifdef BKA_OVF_EN
        assign w_mid_amsb = r_s1_a[WIDTH-1];
`endif
    end

    // ---------------- down-sweep (distribution) ----------------
    // After it, bit i holds the prefix group [i:0]. At level k the bits that
    // sit halfway between two span-2^(k+1) tops extend from the prefix below.
    logic [WIDTH-1:0] w_gd;
    logic [WIDTH-1:0] w_pd;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;

    always_comb begin
        w_gd = w_mid_g;
        w_pd = w_mid_pp;
        for (int k = c_LEVELS - 2; k >= 0; k--) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((((i + 1) % (2 << k)) == (1 << k)) && (i >= (2 << k))) begin
                    w_gd[i] = w_gd[i] | (w_pd[i] & w_gd[i - (1 << k)]);
                    w_pd[i] = w_pd[i] & w_pd[i - (1 << k)];
                end
            end
        end
        w_c[0] = w_mid_c;
        for (int i = 0; i < WIDTH; i++) begin
            w_c[i+1] = w_gd[i] | (w_pd[i] & w_mid_c);
        end
        w_sum = w_mid_p ^ w_c[WIDTH-1:0];
    end

    // ---------------- S3: result ----------------
    logic             r_s3_vld;
    logic [WIDTH-1:0] r_s3_sum;
    logic             r_s3_cout;
`ifdef BKA_OVF_EN
    logic             r_s3_ovf;
    logic             w_ovf;
    // Equal operand signs give a zero propagate at the msb, so the msb of the
    // sum is the carry into it; overflow is that carry differing from a's sign.
    assign w_ovf = ~w_mid_p[WIDTH-1] & (w_c[WIDTH-1] ^ w_mid_amsb);
`endif

    assign w_s3_en = !r_s3_vld || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_vld  <= 1'b0;
            r_s3_sum  <= '0;
            r_s3_cout <= 1'b0;
`ifdef BKA_OVF_EN
            r_s3_ovf  <= 1'b0;
`endif
        end else if (w_s3_en) begin
            r_s3_vld <= w_mid_vld;
            if (w_mid_vld) begin
                r_s3_sum  <= w_sum;
                r_s3_cout <= w_c[WIDTH];
`ifdef BKA_OVF_EN
                r_s3_ovf  <= w_ovf;
`endif
            end
        end
    end

    assign out_valid = r_s3_vld;
    assign sum       = r_s3_sum;
    assign cout      = r_s3_cout;
`ifdef BKA_OVF_EN
    assign ovf       = r_s3_ovf;
`endif

endmodule
`default_nettype wire
